// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller:
// active-high glyphs {dp,g,f,e,d,c,b,a}, converter states and sizing helpers.
package display_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  typedef enum logic [1:0] {
    CAPTURA  = 2'd0,
    DESPLAZA = 2'd1,
    CARGA    = 2'd2
  } estado_t;

  function automatic int unsigned bcd_width(input int unsigned n_digits);
    return 4 * n_digits;
  endfunction

  // Nibbles above 9 cannot come out of the converter; they map to blank.
  function automatic logic [7:0] glifo(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin_a_bcd.sv
// Sequential double-dabble: one capture cycle, DATA_W shift cycles, one
// load cycle. The top nibble carrying out flags a value beyond N_DIGITS.
module bin_a_bcd
  import display_pkg::*;
#(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned N_DIGITS = 4,
  localparam int unsigned BCD_W   = bcd_width(N_DIGITS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inicio,
  input  logic [DATA_W-1:0] binario,
  output logic [BCD_W-1:0]  bcd,
  output logic              desborde,
  output logic              listo
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  estado_t             estado_q, estado_d;
  logic [DATA_W-1:0]   desp_q, desp_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    ajuste;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= CAPTURA;
      desp_q   <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      desp_q   <= desp_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    desp_d   = desp_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    listo    = 1'b0;
    ajuste   = bcd_q;
    case (estado_q)
      CAPTURA: begin
        if (inicio) begin
          desp_d   = binario;
          bcd_d    = '0;
          ovf_d    = 1'b0;
          cnt_d    = '0;
          estado_d = DESPLAZA;
        end
      end
      DESPLAZA: begin
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
          if (ajuste[4*i +: 4] >= 4'd5) ajuste[4*i +: 4] = ajuste[4*i +: 4] + 4'd3;
        end
        bcd_d  = {ajuste[BCD_W-2:0], desp_q[DATA_W-1]};
        ovf_d  = ovf_q | ajuste[BCD_W-1];
        desp_d = desp_q << 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) estado_d = CARGA;
      end
      CARGA: begin
        listo    = 1'b1;
        estado_d = CAPTURA;
      end
      default: estado_d = CAPTURA;
    endcase
  end

  assign bcd      = bcd_q;
  assign desborde = ovf_q;

endmodule

// File: rtl/controlador_display_multiplexado.sv
// Channel-selectable BCD display driver: holds each finished conversion in a
// buffer and scans it onto a multiplexed N-digit 7-segment display.
module controlador_display_multiplexado
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   dato_a,
  input  logic [DATA_W-1:0]   dato_b,
  input  logic                control,
  input  logic                blank_ceros,
  input  logic [N_DIGITS-1:0] punto,
  output logic [N_DIGITS-1:0] selec_digito,
  output logic [7:0]          numero_cod,
  output logic                desborde
);

  localparam int unsigned BCD_W = bcd_width(N_DIGITS);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam logic        INV   = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] SEL_OFF = {N_DIGITS{INV}};
  localparam logic [7:0]          COD_OFF = {8{INV}};

  logic [BCD_W-1:0]    conv_bcd;
  logic                conv_ovf;
  logic                conv_listo;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BCD_W-1:0]    buf_q, buf_d;
  logic                ovf_q, ovf_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]          cod_q, cod_d;

  logic                wrap;
  logic [3:0]          nib;
  logic                dp;
  logic                lz;
  logic [7:0]          seg;
  logic [N_DIGITS-1:0] onehot;

  bin_a_bcd #(
    .DATA_W   (DATA_W),
    .N_DIGITS (N_DIGITS)
  ) u_conv (
    .clock    (clock),
    .reset    (reset),
    .inicio   (1'b1),
    .binario  (control ? dato_a : dato_b),
    .bcd      (conv_bcd),
    .desborde (conv_ovf),
    .listo    (conv_listo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
      buf_q <= '0;
      ovf_q <= 1'b0;
      sel_q <= SEL_OFF;
      cod_q <= COD_OFF;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
      ovf_q <= ovf_d;
      sel_q <= sel_d;
      cod_q <= cod_d;
    end
  end

  // Output stage decodes the current index/buffer, so a wrap and a buffer
  // load on the same edge both become visible together one edge later.
  always_comb begin
    wrap  = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d = wrap ? '0 : pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    buf_d = conv_listo ? conv_bcd : buf_q;
    ovf_d = conv_listo ? conv_ovf : ovf_q;

    nib = 4'd0;
    dp  = 1'b0;
    lz  = 1'b1;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (IDX_W'(j) == idx_q) begin
        nib = buf_q[4*j +: 4];
        dp  = punto[j];
      end
      if (j >= 32'(idx_q) && buf_q[4*j +: 4] != 4'd0) lz = 1'b0;
    end

    if (ovf_q)                                     seg = SEG_DASH | {dp, 7'b0};
    else if (blank_ceros && idx_q != '0 && lz)     seg = SEG_BLANK;
    else                                           seg = glifo(nib) | {dp, 7'b0};

    onehot = N_DIGITS'(1) << idx_q;
    sel_d  = INV ? ~onehot : onehot;
    cod_d  = INV ? ~seg : seg;
  end

  assign selec_digito = sel_q;
  assign numero_cod   = cod_q;
  assign desborde     = ovf_q;

endmodule

// File: doc/controlador_display_multiplexado.md
# controlador_display_multiplexado

Parametrised successor to the team's 7-segment encoder. It selects one of two binary measurement channels (frequency or current), converts the value to BCD with a sequential double-dabble converter, and drives a time-multiplexed N-digit common-anode display. Adds leading-zero blanking, per-digit decimal points, an overflow indication, and a clean sampled-and-held display buffer so a digit never shows a partially converted value. Sits between the DPWM measurement logic and the board's display pins.

## Interface
- N_DIGITS, 4, number of display digits (1..8)
- DATA_W, 10, width of each input channel (1..27)
- SCAN_DIV, 50000, clock cycles each digit stays lit (≥2)
- ACTIVE_LOW, 1, 1 = anode and segment outputs active-low (Nexys 3)
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- dato_a  in  DATA_W  channel A (frequency), unsigned
- dato_b  in  DATA_W  channel B (current), unsigned
- control  in  1  1 = show dato_a, 0 = show dato_b
- blank_ceros  in  1  1 = blank leading zeros (digit 0 always shown)
- punto  in  N_DIGITS  decimal-point enable per digit, bit i = digit i
- selec_digito  out  N_DIGITS  one-hot anode enables, digit 0 = least significant
- numero_cod  out  8  {dp,g,f,e,d,c,b,a} for the lit digit
- desborde  out  1  high while the displayed value exceeds 10^N_DIGITS−1

## Operation
- Converter FSM: CAPTURA → DESPLAZA → CARGA → CAPTURA, running continuously.
- CAPTURA (1 cycle): latch `control ? dato_a : dato_b` into the shift register. Clear the BCD accumulator and the sticky overflow flag.
- DESPLAZA (DATA_W cycles): first add 3 to every BCD nibble ≥5. Then shift left one bit, with the binary MSB entering BCD bit 0. A 1 shifted out of the top nibble sets the sticky overflow flag.
- CARGA (1 cycle): copy the BCD accumulator and overflow flag into the display buffer atomically. `desborde` updates here.
- Changes to inputs outside CAPTURA have no effect until the next capture.
- Scan: prescaler counts 0..SCAN_DIV−1. At wrap, digit index increments modulo N_DIGITS.
- Per-digit decode, in priority order:
  - overflow → dash (segment g only)
  - leading zero with blank_ceros=1 and index>0 → blank
  - otherwise glyph 0–9
- Leading zero: the digit and all higher digits are 0.
- dp = punto[index] when not blanked. Blank digits also suppress dp. Overflow digits keep dp.
- When ACTIVE_LOW=1, both selec_digito and numero_cod are bitwise inverted at the output register.

## Timing
- Reset values:
  - selec_digito all inactive (all ones if ACTIVE_LOW, else zeros)
  - numero_cod all off (8'hFF / 8'h00)
  - desborde=0
  - FSM in CAPTURA; prescaler, index and display buffer 0
- First lit digit appears on the first cycle after reset deasserts.
- Conversion period DATA_W+2 cycles. The captured value is in the display buffer DATA_W+2 cycles after the capture edge. It is visible on outputs one cycle later, when that digit is lit.
- selec_digito and numero_cod are registered and change on the same edge. There are no combinational paths from any input to the outputs.
- CARGA coinciding with a prescaler wrap: the new digit uses the new buffer contents.
- Reset asserted mid-conversion or mid-scan: all state returns to reset values on that edge. A partial conversion is discarded.
- Input value 0 with blank_ceros=1: only digit 0 shows "0".

## Structure
- Shared package `display_pkg`:
  - segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH (active-high)
  - converter state encoding CAPTURA/DESPLAZA/CARGA
  - function for N_DIGITS×4 buffer width
- Sub-module `bin_a_bcd`: sequential double-dabble, parameters DATA_W and N_DIGITS.
  - Ports: clock, reset, inicio, binario, bcd, desborde, listo.
- The scan counter, blanking and output registers stay in the top level.

## Test plan
All cases use N_DIGITS=4, DATA_W=10, SCAN_DIV=4, ACTIVE_LOW=1 unless stated.
- Reset held 3 cycles → selec_digito=4'b1111, numero_cod=8'hFF, desborde=0. Release → digit 0 lit next cycle.
- control=1, dato_a=1023, punto=0 → after ≤13 cycles:
  - digits 3..0 show 1,0,2,3
  - digit 0 numero_cod=8'hB0 while selec_digito=4'b1110
  - each digit lit exactly 4 cycles, order 0,1,2,3,0
- control=0, dato_b=7, blank_ceros=1, punto=4'b0010:
  - digits 3,2 = 8'hFF
  - digit 1 = 8'hFF (blank suppresses dp)
  - digit 0 = 8'hF8
- N_DIGITS=2, dato_a=100 → desborde=1, both digits numero_cod=8'hBF. Then dato_a=99 → desborde=0 within 13 cycles, digits show 9,9 (8'h90).
- Toggle control and change dato_a/dato_b every cycle during DESPLAZA → the displayed value always equals a value sampled at a CAPTURA edge. The buffer never mixes digits from two samples.
- Assert reset during DESPLAZA and at a prescaler wrap → all outputs at reset values on the next cycle. The first post-reset conversion completes in 12 cycles.
